pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_lock_sequencer.sv | 128 ++++++++++++
 tb/tb_pll_lock_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: synchronizes the PLL lock flag, qualifies it, releases the
// downstream reset, and resets the PLL when lock never arrives.
//
// state      | meaning
// WAIT_LOCK  | waiting for synchronized lock, timeout running
// STABILIZE  | lock seen, counting consecutive stable cycles
// HOLD       | lock trusted, downstream reset still held
// RUN        | downstream logic released, watching for lock loss
// PLL_RESET  | pll_rst pulse in progress, lock flag ignored
module pll_lock_sequencer #(
   parameter int SYNC_STAGES    = 2,
   parameter int STABLE_CYCLES  = 4800,
   parameter int RESET_HOLD     = 16,
   parameter int LOCK_TIMEOUT   = 480000,
   parameter int PLL_RST_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       locked,
   output logic       pll_rst,
   output logic       rst_out,
   output logic       ready,
   output logic [7:0] loss_cnt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      STABILIZE = 3'd1,
      HOLD      = 3'd2,
      RUN       = 3'd3,
      PLL_RESET = 3'd4
   } state_e;

   localparam int TMO_W  = (LOCK_TIMEOUT   > 1) ? $clog2(LOCK_TIMEOUT)   : 1;
   localparam int STAB_W = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES)  : 1;
   localparam int HOLD_W = (RESET_HOLD     > 1) ? $clog2(RESET_HOLD)     : 1;
   localparam int PRST_W = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;

   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
   localparam logic [PRST_W-1:0] PRST_LAST = PRST_W'(PLL_RST_CYCLES - 1);

   // Plain vector so an illegal code can be observed and recovered from
   logic [2:0]             state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic [STAB_W-1:0]      stab_q, stab_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic [PRST_W-1:0]      prst_q, prst_d;
   logic [7:0]             loss_q, loss_d;
   logic                   rst_out_q, ready_q, pll_rst_q;
   logic                   lk;

   assign lk = sync_q[SYNC_STAGES-1];

   // Counters idle at zero outside their own state, so every entry starts fresh
   always_comb begin
      state_d = state_q;
      tmo_d   = '0;
      stab_d  = '0;
      hold_d  = '0;
      prst_d  = '0;
      loss_d  = loss_q;
      case (state_q)
         WAIT_LOCK: begin
            if (lk)                     state_d = STABILIZE;
            else if (tmo_q == TMO_LAST) state_d = PLL_RESET;
            else                        tmo_d   = tmo_q + TMO_W'(1);
         end
         STABILIZE: begin
            if (!lk)                      state_d = WAIT_LOCK;
            else if (stab_q == STAB_LAST) state_d = HOLD;
            else                          stab_d  = stab_q + STAB_W'(1);
         end
         HOLD: begin
            if (!lk)                      state_d = WAIT_LOCK;
            else if (hold_q == HOLD_LAST) state_d = RUN;
            else                          hold_d  = hold_q + HOLD_W'(1);
         end
         RUN: begin
            if (!lk) begin
               state_d = WAIT_LOCK;
               if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
            end
         end
         PLL_RESET: begin
            if (prst_q == PRST_LAST) state_d = WAIT_LOCK;
            else                     prst_d  = prst_q + PRST_W'(1);
         end
         default: state_d = WAIT_LOCK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= WAIT_LOCK;
         sync_q    <= '0;
         tmo_q     <= '0;
         stab_q    <= '0;
         hold_q    <= '0;
         prst_q    <= '0;
         loss_q    <= '0;
         rst_out_q <= 1'b1;
         ready_q   <= 1'b0;
         pll_rst_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= {sync_q[SYNC_STAGES-2:0], locked};
         tmo_q     <= tmo_d;
         stab_q    <= stab_d;
         hold_q    <= hold_d;
         prst_q    <= prst_d;
         loss_q    <= loss_d;
         rst_out_q <= (state_d != RUN);
         ready_q   <= (state_d == RUN);
         pll_rst_q <= (state_d == PLL_RESET);
      end
   end

   assign pll_rst  = pll_rst_q;
   assign rst_out  = rst_out_q;
   assign ready    = ready_q;
   assign loss_cnt = loss_q;
   assign state    = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: expected latencies and values are
// queued when stimulus is applied and compared when the DUT responds.
module tb_pll_lock_sequencer;

   localparam int SYNC   = 2;
   localparam int STABLE = 8;
   localparam int HOLDC  = 4;
   localparam int TMO    = 50;
   localparam int PRST   = 5;

   localparam int T_READY = SYNC + 1 + STABLE + HOLDC;
   localparam int T_LOSS  = SYNC + 1;
   localparam int PERIOD  = TMO + PRST;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       locked = 1'b0;
   logic       pll_rst, rst_out, ready;
   logic [7:0] loss_cnt;
   logic [2:0] state;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_q[$];

   pll_lock_sequencer #(
      .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .RESET_HOLD(HOLDC),
      .LOCK_TIMEOUT(TMO), .PLL_RST_CYCLES(PRST)
   ) dut (
      .clk(clk), .rst(rst), .locked(locked), .pll_rst(pll_rst),
      .rst_out(rst_out), .ready(ready), .loss_cnt(loss_cnt), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_pop(input string tag, input int obs);
      int e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -9999;
      chk(tag, obs, e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic lk_val);
      @(negedge clk);
      rst = 1'b1;
      locked = lk_val;
      tick();
      tick();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_ready(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (ready) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_rst_out(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (rst_out) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      int  rise_at, width;
      logic prev;
      logic saw;

      // Reset state
      @(negedge clk);
      rst = 1'b1;
      tick();
      tick();
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
      exp_q.push_back(0); exp_q.push_back(0);
      chk_pop("rst_state", state);
      chk_pop("rst_rst_out", rst_out);
      chk_pop("rst_ready", ready);
      chk_pop("rst_pll_rst", pll_rst);
      chk_pop("rst_loss", loss_cnt);

      // Clean lock from reset release
      @(negedge clk);
      rst = 1'b0;
      locked = 1'b1;
      exp_q.push_back(T_READY);
      exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(0);
      wait_ready(100, n);
      chk_pop("clean_ready_lat", n);
      chk_pop("clean_rst_out", rst_out);
      chk_pop("clean_state", state);
      chk_pop("clean_loss", loss_cnt);

      // One-cycle dropout restarts stabilization
      do_reset(1'b0);
      locked = 1'b1;
      repeat (5) @(negedge clk);
      locked = 1'b0;
      @(negedge clk);
      locked = 1'b1;
      exp_q.push_back(T_READY);
      wait_ready(100, n);
      chk_pop("glitch_restart_lat", n);

      // Lock one cycle short of the stable window never reaches HOLD
      do_reset(1'b0);
      locked = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < STABLE - 1; i++) begin
         tick();
         if (state == 3'd2 || ready) saw = 1'b1;
      end
      @(negedge clk);
      locked = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (state == 3'd2 || ready) saw = 1'b1;
      end
      exp_q.push_back(0);
      chk_pop("short_lock_no_hold", saw);

      // Lock never arrives: periodic pll_rst pulses
      do_reset(1'b0);
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(TMO + k * PERIOD);
         exp_q.push_back(PRST);
      end
      prev = 1'b0;
      rise_at = 0;
      for (int i = 1; i <= 3 * PERIOD + 5; i++) begin
         tick();
         if (pll_rst && !prev) begin
            rise_at = i;
            chk_pop("prst_rise_edge", i);
         end
         if (!pll_rst && prev) begin
            width = i - rise_at;
            chk_pop("prst_width", width);
         end
         prev = pll_rst;
      end
      chk("prst_events_left", exp_q.size(), 0);
      exp_q.delete();

      // Lock losses in RUN and loss counter saturation
      do_reset(1'b1);
      wait_ready(100, n);
      @(negedge clk);
      locked = 1'b0;
      exp_q.push_back(T_LOSS); exp_q.push_back(0); exp_q.push_back(1);
      wait_rst_out(20, n);
      chk_pop("loss_rst_out_lat", n);
      chk_pop("loss_ready", ready);
      chk_pop("loss_cnt_1", loss_cnt);
      for (int k = 2; k <= 300; k++) begin
         @(negedge clk);
         locked = 1'b1;
         wait_ready(40, n);
         if (n != T_READY) chk("relock_lat", n, T_READY);
         @(negedge clk);
         locked = 1'b0;
         wait_rst_out(20, n);
         if (n != T_LOSS) chk("reloss_lat", n, T_LOSS);
         if (k == 10)  chk("loss_cnt_10", loss_cnt, 10);
         if (k == 255) chk("loss_cnt_255", loss_cnt, 255);
      end
      chk("loss_cnt_sat", loss_cnt, 255);

      // Reset in the second cycle of a pll_rst pulse
      n = -1;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (pll_rst) begin
            n = i;
            break;
         end
      end
      chk("prst_seen_before_rst", (n > 0) ? 1 : 0, 1);
      tick();
      @(negedge clk);
      rst = 1'b1;
      exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
      tick();
      chk_pop("mid_rst_pll_rst", pll_rst);
      chk_pop("mid_rst_state", state);
      chk_pop("mid_rst_loss", loss_cnt);
      chk_pop("mid_rst_rst_out", rst_out);
      @(negedge clk);
      rst = 1'b0;

      // Illegal state code recovers to WAIT_LOCK
      @(negedge clk);
      force dut.state_q = 3'd6;
      #1;
      release dut.state_q;
      exp_q.push_back(0); exp_q.push_back(1);
      tick();
      chk_pop("illegal_state_recover", state);
      chk_pop("illegal_state_rst_out", rst_out);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
